i2s_tx_stereo: RTL and testbench
================================

// Module: i2s_tx_stereo
// PURPOSE
//  Parametrised stereo PCM/I2S serial transmitter, the next generation of the 16-bit mono audio output.
//  Takes left/right samples over a valid/ready handshake and buffers one sample pair.
//  Generates bclk/lrclk from clk and shifts the data out MSB-first.
//  Sits between the audio sample source (mic path/DSP) and the codec DAC pins.
// PARAMETERS
//  DATA_W   16  sample width per channel, bits
//  SLOT_W   32  bclk cycles per channel slot; must be >= DATA_W; pad bits are 0
//  CLK_DIV  4   clk cycles per bclk half-period; must be >= 1; bclk period = 2*CLK_DIV clk
//  I2S_MODE 1   1: Philips I2S (MSB one bclk after lrclk edge); 0: left-justified
// PORTS
//  clk       in   1       system clock
//  reset     in   1       synchronous, active-high
//  enable    in   1       1: run serial interface; 0: idle
//  d_left    in   DATA_W  left sample, two's complement
//  d_right   in   DATA_W  right sample
//  valid     in   1       sample pair present on d_left/d_right
//  ready     out  1       holding register empty; pair accepted when valid&&ready
//  bclk      out  1       bit clock
//  lrclk     out  1       0 = left slot, 1 = right slot
//  d_out     out  1       serial data; changes on bclk fall; sink samples it on bclk rise
//  done      out  1       1-clk pulse at each frame boundary (pair loaded into shifter)
//  underrun  out  1       1-clk pulse when a frame starts with the holding register empty
// BEHAVIOUR
//  - Reset (all registered):
//    - bclk=0, lrclk=0, d_out=0, done=0, underrun=0, ready=1.
//    - Holding register empty; shifter=0; div_cnt=0; bit_cnt=2*SLOT_W-1.
//  - Divider: div_cnt counts 0..CLK_DIV-1 while enable=1; at CLK_DIV-1 bclk toggles.
//    - fall_evt = terminal && bclk==1; rise_evt = terminal && bclk==0.
//  - On fall_evt:
//    - bit_cnt advances, wrapping 2*SLOT_W-1 -> 0.
//    - lrclk <= (new bit_cnt >= SLOT_W).
//    - Shifter shifts left one bit.
//  - Frame load (fall_evt with wrap to 0):
//    - Shifter <= {L, SLOT_W-DATA_W zeros, R, SLOT_W-DATA_W zeros}.
//    - Holding register marked empty; done pulses.
//    - If holding was empty: load all zeros and pulse underrun with done.
//  - d_out:
//    - I2S_MODE=0: shifter MSB.
//    - I2S_MODE=1: 1-bit reg loaded with shifter MSB on each fall_evt, so every bit is delayed one bclk.
//      First bit of a frame is the last pad bit (0) of the previous one.
//  - Handshake: ready = !hold_full (registered).
//    - valid&&ready writes the pair, so ready=0 from the next clk.
//    - Load on the same clk as a write sees the pre-write state: empty -> underrun; new pair kept for next frame.
//    - Full holding + load: ready=1 next clk.
//  - Timing: first frame starts CLK_DIV*2 clk after enable rises.
//    - Frame length = 2*SLOT_W*2*CLK_DIV clk.
//  - enable=0 (any time, incl. mid-frame) resets all of these; holding register and handshake stay live:
//    - div_cnt, bclk, lrclk, d_out, shifter and bit_cnt (to 2*SLOT_W-1).
//  - reset mid-frame aborts the frame and discards the buffered pair; no done/underrun pulse.
// STRUCTURE
//  - Package i2s_pkg: I2S_MODE encodings (MODE_LJ=0, MODE_I2S=1) and frame length function 2*SLOT_W.
//  - Sub-module i2s_bclk_gen (clk, reset, enable -> bclk, fall_evt, rise_evt), parameter CLK_DIV.
//  - Top holds the holding register, bit counter, shifter and output regs.
// TESTING
//  1. DATA_W=16, SLOT_W=16, CLK_DIV=2, I2S_MODE=0; push L=16'hA55A, R=16'h0FF0.
//     -> Bits sampled on bclk rise are A55A while lrclk=0, then 0FF0 while lrclk=1.
//     -> bclk period 4 clk; done every 128 clk.
//  2. Same, I2S_MODE=1.
//     -> Each bit one bclk later than in test 1; first bit after lrclk fall = 0, then A55A MSB.
//  3. No valid after the first pair.
//     -> Next frame all zeros; underrun and done pulse together, 1 clk wide; ready stays 1.
//  4. DATA_W=16, SLOT_W=24; push L=16'hFFFF, R=16'h8001.
//     -> Per slot: 16 data bits then 8 zeros; lrclk high for exactly 24 bclk.
//  5. Hold valid=1 continuously.
//     -> Exactly one pair accepted per frame; ready low except the clk after each load; no underrun.
//  6. Drop enable, and separately assert reset, at bit 7 of the left slot.
//     -> bclk/lrclk/d_out = 0 next clk.
//     -> Re-enable: a full frame starts cleanly (enable case keeps the buffered pair; reset case underruns).

Source files
------------

// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared constants and helpers for the stereo I2S transmitter
// Purpose: I2S_MODE encodings and the frame-length helper.
// Ports: none (package).
package i2s_pkg;

  localparam int MODE_LJ  = 0;  // left-justified: MSB coincides with the lrclk edge
  localparam int MODE_I2S = 1;  // Philips I2S: MSB one bclk after the lrclk edge

  // bclk cycles per stereo frame
  function automatic int frame_bits(input int slot_w);
    return 2 * slot_w;
  endfunction

endpackage

// File: rtl/i2s_tx_stereo_if.sv
// rtl/i2s_tx_stereo_if.sv - sample-pair handshake between source and transmitter
// Purpose: groups the left/right sample bus with its valid/ready handshake.
// Ports: d_left, d_right (sample pair), valid (pair present), ready (transmitter can accept).
interface i2s_tx_stereo_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] d_left;
  logic [DATA_W-1:0] d_right;
  logic              valid;
  logic              ready;

  modport master (output d_left, output d_right, output valid, input ready);
  modport slave  (input d_left, input d_right, input valid, output ready);
endinterface

// File: rtl/i2s_bclk_gen.sv
// rtl/i2s_bclk_gen.sv - bit-clock divider with edge strobes
// Purpose: divides clk by 2*CLK_DIV into bclk and flags the clk cycle on which bclk rises or falls.
// Ports: clk, reset (sync, active-high), enable (0 holds divider idle with bclk low),
//        bclk (bit clock), fall_evt / rise_evt (1-clk strobes, coincident with the bclk toggle).
module i2s_bclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic bclk,
  output logic fall_evt,
  output logic rise_evt
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;
  logic          terminal;

  assign terminal = enable && (div_cnt == TERM);
  // The strobes describe the toggle happening on this clk edge, so they key off the old bclk level.
  assign fall_evt = terminal && bclk;
  assign rise_evt = terminal && !bclk;

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (terminal) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tx_stereo.sv
// rtl/i2s_tx_stereo.sv - parametrised stereo PCM/I2S serial transmitter
// Purpose: buffers one left/right pair, frames it into two SLOT_W-bit slots and shifts it out MSB-first.
// Ports: clk, reset (sync, active-high), enable (0 idles the serial side),
//        s_if (sample-pair handshake, slave side), bclk, lrclk (0 left / 1 right), d_out (serial data),
//        done (1-clk pulse per frame load), underrun (1-clk pulse when a frame loads with no pair buffered).
module i2s_tx_stereo
  import i2s_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int SLOT_W   = 32,
  parameter int CLK_DIV  = 4,
  parameter int I2S_MODE = MODE_I2S
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  i2s_tx_stereo_if.slave s_if,
  output logic bclk,
  output logic lrclk,
  output logic d_out,
  output logic done,
  output logic underrun
);

  localparam int FRAME = frame_bits(SLOT_W);
  localparam int BW    = $clog2(FRAME);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME - 1);

  logic              fall_evt;
  logic              bclk_rise_unused;
  logic [DATA_W-1:0] hold_l;
  logic [DATA_W-1:0] hold_r;
  logic              hold_full;
  logic              hold_full_nxt;
  logic              ready_q;
  logic [FRAME-1:0]  shifter;
  logic [FRAME-1:0]  frame_word;
  logic [BW-1:0]     bit_cnt;
  logic [BW-1:0]     bit_cnt_nxt;
  logic              wrap;
  logic              load;
  logic              write;
  logic              d_reg;

  i2s_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk_gen (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .bclk     (bclk),
    .fall_evt (fall_evt),
    .rise_evt (bclk_rise_unused)
  );

  assign wrap        = (bit_cnt == LAST_BIT);
  assign bit_cnt_nxt = wrap ? '0 : bit_cnt + 1'b1;
  assign load        = fall_evt && wrap;
  assign write       = s_if.valid && ready_q;
  assign s_if.ready  = ready_q;

  // Each sample sits at the top of its slot; the pad bits below it stay zero.
  assign frame_word = (FRAME'(hold_l) << (FRAME - DATA_W))
                    | (FRAME'(hold_r) << (SLOT_W - DATA_W));

  // A load sees the pre-write state, so a pair written on the load clk survives for the next frame.
  always_comb begin
    hold_full_nxt = hold_full;
    if (load)  hold_full_nxt = 1'b0;
    if (write) hold_full_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_l    <= '0;
      hold_r    <= '0;
      hold_full <= 1'b0;
      ready_q   <= 1'b1;
      done      <= 1'b0;
      underrun  <= 1'b0;
      shifter   <= '0;
      bit_cnt   <= LAST_BIT;
      lrclk     <= 1'b0;
      d_reg     <= 1'b0;
    end else begin
      hold_full <= hold_full_nxt;
      ready_q   <= !hold_full_nxt;
      done      <= load;
      underrun  <= load && !hold_full;
      if (write) begin
        hold_l <= s_if.d_left;
        hold_r <= s_if.d_right;
      end
      if (!enable) begin
        shifter <= '0;
        bit_cnt <= LAST_BIT;
        lrclk   <= 1'b0;
        d_reg   <= 1'b0;
      end else if (fall_evt) begin
        bit_cnt <= bit_cnt_nxt;
        lrclk   <= (bit_cnt_nxt >= BW'(SLOT_W));
        // Captures the bit leaving the shifter, giving the one-bclk I2S delay.
        d_reg   <= shifter[FRAME-1];
        if (load) shifter <= hold_full ? frame_word : '0;
        else      shifter <= shifter << 1;
      end
    end
  end

  assign d_out = (I2S_MODE == MODE_I2S) ? d_reg : shifter[FRAME-1];

endmodule

// File: tb/tb_i2s_tx_stereo.sv
// tb/tb_i2s_tx_stereo.sv - self-checking bench for i2s_tx_stereo
module tb_i2s_tx_stereo;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] dl;
  logic [15:0] dr;
  logic        valid_tb;
  logic [1:0]  sel;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2s_tx_stereo_if #(.DATA_W(16)) if0 ();
  i2s_tx_stereo_if #(.DATA_W(16)) if1 ();
  i2s_tx_stereo_if #(.DATA_W(16)) if2 ();

  assign if0.d_left  = dl;
  assign if0.d_right = dr;
  assign if0.valid   = valid_tb && (sel == 2'd0);
  assign if1.d_left  = dl;
  assign if1.d_right = dr;
  assign if1.valid   = valid_tb && (sel == 2'd1);
  assign if2.d_left  = dl;
  assign if2.d_right = dr;
  assign if2.valid   = valid_tb && (sel == 2'd2);

  logic [2:0] bclk_v, lr_v, do_v, done_v, un_v;

  i2s_tx_stereo #(.DATA_W(16), .SLOT_W(16), .CLK_DIV(2), .I2S_MODE(0)) dut_lj (
    .clk(clk), .reset(reset), .enable(enable), .s_if(if0.slave),
    .bclk(bclk_v[0]), .lrclk(lr_v[0]), .d_out(do_v[0]), .done(done_v[0]), .underrun(un_v[0]));

  i2s_tx_stereo #(.DATA_W(16), .SLOT_W(16), .CLK_DIV(2), .I2S_MODE(1)) dut_i2s (
    .clk(clk), .reset(reset), .enable(enable), .s_if(if1.slave),
    .bclk(bclk_v[1]), .lrclk(lr_v[1]), .d_out(do_v[1]), .done(done_v[1]), .underrun(un_v[1]));

  i2s_tx_stereo #(.DATA_W(16), .SLOT_W(24), .CLK_DIV(2), .I2S_MODE(0)) dut_s24 (
    .clk(clk), .reset(reset), .enable(enable), .s_if(if2.slave),
    .bclk(bclk_v[2]), .lrclk(lr_v[2]), .d_out(do_v[2]), .done(done_v[2]), .underrun(un_v[2]));

  logic bclk_s, lr_s, do_s, done_s, un_s, ready_s;
  assign bclk_s  = bclk_v[sel];
  assign lr_s    = lr_v[sel];
  assign do_s    = do_v[sel];
  assign done_s  = done_v[sel];
  assign un_s    = un_v[sel];
  assign ready_s = (sel == 2'd0) ? if0.ready : (sel == 2'd1) ? if1.ready : if2.ready;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic timed_out(input string name);
    n_chk++;
    $display("FAIL %s: got timeout expected DUT event", name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; enable = 1'b0; valid_tb = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    dl = l; dr = r; valid_tb = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (ready_s) begin
        @(negedge clk);
        valid_tb = 1'b0;
        return;
      end
      @(negedge clk);
    end
    valid_tb = 1'b0;
    timed_out("push");
  endtask

  task automatic wait_done(output int t);
    t = -1;
    for (int i = 0; i < 1000; i++) begin
      if (done_s) begin
        t = cyc;
        return;
      end
      @(negedge clk);
    end
    timed_out("wait_done");
  endtask

  task automatic capture(input int n, output logic [63:0] d, output logic [63:0] lr);
    logic prev;
    int   k;
    d = '0; lr = '0; k = 0;
    prev = bclk_s;
    for (int i = 0; i < 5000 && k < n; i++) begin
      @(negedge clk);
      if (!prev && bclk_s) begin
        d  = {d[62:0], do_s};
        lr = {lr[62:0], lr_s};
        k++;
      end
      prev = bclk_s;
    end
    if (k < n) timed_out("capture");
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] l;
    logic [15:0] r;
    int          nbits;
    logic [63:0] exp_d;
    logic [63:0] exp_lr;
    logic [63:0] exp_zero;
  } vec_t;

  vec_t vt[5];

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] d, lr;
    int t0, t1, t2;
    int rdy_hi, acc, un_cnt;

    reset = 1'b1; enable = 1'b0; valid_tb = 1'b0; sel = 2'd0; dl = '0; dr = '0;

    vt[0] = '{2'd0, 16'hA55A, 16'h0FF0, 32, 64'hA55A0FF0,     64'h0000FFFF,     64'h0};
    vt[1] = '{2'd1, 16'hA55A, 16'h0FF0, 32, 64'h52AD07F8,     64'h0000FFFF,     64'h0};
    vt[2] = '{2'd2, 16'hFFFF, 16'h8001, 48, 64'hFFFF00800100, 64'h000000FFFFFF, 64'h0};
    vt[3] = '{2'd0, 16'h8001, 16'h7FFE, 32, 64'h80017FFE,     64'h0000FFFF,     64'h0};
    vt[4] = '{2'd1, 16'hFFFF, 16'h0001, 32, 64'h7FFF8000,     64'h0000FFFF,     64'h80000000};

    for (int i = 0; i < 5; i++) begin
      sel = vt[i].sel;
      do_reset();
      check("reset_state", 64'({bclk_s, lr_s, do_s, done_s, un_s, ready_s}), 64'b000001);
      push(vt[i].l, vt[i].r);
      check("ready_after_push", 64'(ready_s), 64'd0);
      enable = 1'b1;
      t0 = cyc;
      wait_done(t1);
      check("first_frame_latency", 64'(t1 - t0), 64'd4);
      check("first_underrun", 64'(un_s), 64'd0);
      capture(vt[i].nbits, d, lr);
      check("frame_data", d, vt[i].exp_d);
      check("frame_lrclk", lr, vt[i].exp_lr);
      wait_done(t2);
      check("frame_len", 64'(t2 - t1), 64'(vt[i].nbits * 4));
      check("underrun_pulse", 64'({done_s, un_s, ready_s}), 64'b111);
      @(negedge clk);
      check("pulse_width", 64'({done_s, un_s}), 64'b00);
      capture(vt[i].nbits, d, lr);
      check("zero_frame", d, vt[i].exp_zero);
      enable = 1'b0;
    end

    // valid held high: one pair accepted per frame, ready high only right after each load
    sel = 2'd0;
    do_reset();
    dl = 16'h1234; dr = 16'h5678; valid_tb = 1'b1; enable = 1'b1;
    wait_done(t1);
    rdy_hi = 0; acc = 0; un_cnt = 0;
    for (int j = 0; j < 256; j++) begin
      if (ready_s) rdy_hi++;
      if (ready_s && valid_tb) acc++;
      if (un_s) un_cnt++;
      @(negedge clk);
    end
    check("stream_ready_cycles", 64'(rdy_hi), 64'd2);
    check("stream_accepts", 64'(acc), 64'd2);
    check("stream_underruns", 64'(un_cnt), 64'd0);
    valid_tb = 1'b0; enable = 1'b0;

    // enable dropped at bit 7 of the left slot; buffered pair survives
    do_reset();
    push(16'hA55A, 16'h0FF0);
    enable = 1'b1;
    wait_done(t1);
    capture(8, d, lr);
    check("pre_drop_bits", 64'(d[7:0]), 64'hA5);
    push(16'h1234, 16'h5678);
    enable = 1'b0;
    @(negedge clk);
    check("enable_drop_outputs", 64'({bclk_s, lr_s, do_s}), 64'b000);
    check("enable_drop_keeps_pair", 64'(ready_s), 64'd0);
    @(negedge clk);
    enable = 1'b1;
    t0 = cyc;
    wait_done(t1);
    check("reenable_latency", 64'(t1 - t0), 64'd4);
    check("reenable_underrun", 64'(un_s), 64'd0);
    capture(32, d, lr);
    check("reenable_data", d, 64'h12345678);
    enable = 1'b0;

    // reset at bit 7 of the left slot; buffered pair discarded
    do_reset();
    push(16'hA55A, 16'h0FF0);
    enable = 1'b1;
    wait_done(t1);
    capture(8, d, lr);
    push(16'h1234, 16'h5678);
    reset = 1'b1;
    @(negedge clk);
    check("reset_abort_outputs", 64'({bclk_s, lr_s, do_s, done_s, un_s, ready_s}), 64'b000001);
    @(negedge clk);
    check("reset_no_pulse", 64'({done_s, un_s}), 64'b00);
    reset = 1'b0;
    t0 = cyc;
    wait_done(t1);
    check("post_reset_latency", 64'(t1 - t0), 64'd4);
    check("post_reset_underrun", 64'(un_s), 64'd1);
    capture(32, d, lr);
    check("post_reset_data", d, 64'h0);
    enable = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
